stream_dma: RTL and testbench
=============================

STREAM_DMA -- requirements
Module: stream_dma

Interface
REQ-001 Parameter DW, default 32, data width of stream and Wishbone data, multiple of 8.
REQ-002 Parameter FIFO_DEPTH, default 8, MM2S prefetch FIFO entries, power of two, 2 or more.
REQ-003 Parameter CFG_BASE, default 32'h3000_0000, byte base address of the register window.
REQ-004 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-low.
REQ-006 wbs_cyc_i  in  1  register-port cycle.
REQ-007 wbs_stb_i  in  1  register-port strobe.
REQ-008 wbs_we_i  in  1  register-port write enable.
REQ-009 wbs_adr_i  in  32  register-port byte address.
REQ-010 wbs_dat_i  in  32  register-port write data.
REQ-011 wbs_ack_o  out  1  register-port acknowledge.
REQ-012 wbs_dat_o  out  32  register-port read data.
REQ-013 m_cyc_o  out  1  master cycle; always equal to m_stb_o.
REQ-014 m_stb_o  out  1  master strobe.
REQ-015 m_we_o  out  1  master write enable.
REQ-016 m_adr_o  out  32  master byte address.
REQ-017 m_dat_o  out  DW  master write data.
REQ-018 m_dat_i  in  DW  master read data.
REQ-019 m_ack_i  in  1  master acknowledge.
REQ-020 ss_tdata/ss_tvalid/ss_tlast  out  DW/1/1  MM2S stream; ss_tready  in  1.
REQ-021 sm_tdata/sm_tvalid  in  DW/1  S2MM stream; sm_tready  out  1.
REQ-022 irq_o  out  1  level interrupt, equal to done AND irq_en.

Function
REQ-023 Registers at CFG_BASE: +0x0 CTRL (write: bit0 start, bit1 irq_en; read: bit0 busy, bit1 irq_en, bit2 done), +0x4 SRC, +0x8 DST, +0xC LEN in words (16 bits used).
REQ-024 wbs_ack_o: one-cycle pulse in the cycle after stb&cyc on an in-window address; no ack outside the window; no ack while the previous ack is high.
REQ-025 Writes to SRC, DST or LEN while busy are acked and ignored.
REQ-026 Start while busy is ignored; start with LEN=0 sets done next cycle with no bus traffic; any other start sets busy, clears done, and loads the counters.
REQ-027 Master FSM states M_IDLE, M_RD, M_WR; one transaction outstanding; strobe held until m_ack_i.
REQ-028 Read issue rule: issue only when reads remain AND FIFO occupancy plus outstanding reads is below FIFO_DEPTH; read address is SRC+4*n, wrapping modulo 2^32.
REQ-029 Read data is pushed into the FIFO in the ack cycle; FIFO head drives ss_tdata; ss_tvalid = FIFO non-empty; pop on tvalid&tready; ss_tlast high on word LEN-1 only.
REQ-030 sm_tready = busy AND single write-buffer empty AND writes remaining; the accepted word is written to DST+4*k.
REQ-031 Arbitration when read and write are both pending at M_IDLE: grant alternates, with the write first after reset or start.
REQ-032 Done sets, and busy clears, in the cycle after the last write ack, when all LEN reads are complete and the FIFO is empty; simultaneous completion sets done once.
REQ-033 Read and write counters are independent: stream output may run ahead of or behind write-back.

Reset
REQ-034 In the reset cycle: all outputs 0, registers 0, FIFO empty, FSM M_IDLE; reset mid-transfer abandons the bus cycle immediately with no further strobes.

Structure
REQ-035 The register offsets, CTRL bit positions and master FSM state encoding are held in the shared package stream_dma_pkg.
REQ-036 The prefetch FIFO is the sub-module sync_fifo (DW, FIFO_DEPTH) with full, empty and count outputs.

Verification
REQ-037 SRC=0x100, LEN=4, memory 1..4, ss_tready=1 -> ss words 1,2,3,4 in order, tlast on the 4th word only, 4 reads observed on the master port.
REQ-038 ss_tready=0 with LEN=16, FIFO_DEPTH=8 -> exactly 8 reads issued, then the master port stays idle until the first pop.
REQ-039 DST=0x200, LEN=3, sm words A,B,C -> writes to 0x200, 0x204, 0x208; done=1; with irq_en=1, irq_o=1.
REQ-040 Reads and writes pending together, with m_ack_i delayed 3 cycles -> grants alternate W,R,W,R; no transaction is dropped.
REQ-041 LEN=0 start -> done the next cycle with m_stb_o never asserted; a start while busy leaves SRC, LEN and progress unchanged.
REQ-042 Reset asserted with a read strobe outstanding -> next cycle m_stb_o=0, busy=0 and the FIFO is empty.

Source files
------------

// File: rtl/stream_dma_pkg.sv
// Shared constants for stream_dma: register map, CTRL bit positions and
// master FSM encoding, plus the word-address helper used by both engines.
package stream_dma_pkg;

  localparam logic [3:0] OFS_CTRL = 4'h0;
  localparam logic [3:0] OFS_SRC  = 4'h4;
  localparam logic [3:0] OFS_DST  = 4'h8;
  localparam logic [3:0] OFS_LEN  = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_DONE   = 2;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_RD   = 2'd1;
  localparam logic [1:0] M_WR   = 2'd2;

  // base + 4*idx, wrapping modulo 2^32
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/stream_dma_if.sv
// Bus bundle for stream_dma: Wishbone register port, Wishbone master port,
// MM2S (ss_*) and S2MM (sm_*) streams and the interrupt line.
interface stream_dma_if #(parameter int DW = 32);
  logic          wbs_cyc_i;
  logic          wbs_stb_i;
  logic          wbs_we_i;
  logic [31:0]   wbs_adr_i;
  logic [31:0]   wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          m_cyc_o;
  logic          m_stb_o;
  logic          m_we_o;
  logic [31:0]   m_adr_o;
  logic [DW-1:0] m_dat_o;
  logic [DW-1:0] m_dat_i;
  logic          m_ack_i;
  logic [DW-1:0] ss_tdata;
  logic          ss_tvalid;
  logic          ss_tlast;
  logic          ss_tready;
  logic [DW-1:0] sm_tdata;
  logic          sm_tvalid;
  logic          sm_tready;
  logic          irq_o;

  // master: the DMA engine itself; slave: the surrounding system
  modport master (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    input  m_dat_i, m_ack_i,
    output ss_tdata, ss_tvalid, ss_tlast,
    input  ss_tready,
    input  sm_tdata, sm_tvalid,
    output sm_tready,
    output irq_o
  );

  modport slave (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    output m_dat_i, m_ack_i,
    input  ss_tdata, ss_tvalid, ss_tlast,
    output ss_tready,
    output sm_tdata, sm_tvalid,
    input  sm_tready,
    input  irq_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the MM2S prefetch buffer; head word is shown on dout.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/stream_dma.sv
// Two-direction stream DMA: MM2S reads SRC.. into a prefetch FIFO feeding ss_*,
// S2MM takes sm_* words and writes them to DST..; one shared Wishbone master.
module stream_dma
  import stream_dma_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] CFG_BASE   = 32'h3000_0000
) (
  input logic          wb_clk_i,
  input logic          wb_rst_i,
  stream_dma_if.master bus
);

  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]    BASE    = CFG_BASE;

  logic          ack_q, ack_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          irq_en_q, irq_en_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]   src_q, src_d, dst_q, dst_d, adr_q, adr_d;
  logic [15:0]   len_q, len_d;
  logic [1:0]    state_q, state_d;
  logic          prefer_rd_q, prefer_rd_d;
  logic [15:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [15:0]   acc_cnt_q, acc_cnt_d, pop_cnt_q, pop_cnt_d;
  logic          wbuf_vld_q, wbuf_vld_d;
  logic [DW-1:0] wbuf_q, wbuf_d;

  logic          reg_hit, rd_req, wr_req, sm_accept, fifo_nxt_zero;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [DW-1:0] fifo_head;

  sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .push  (fifo_push),
    .din   (bus.m_dat_i),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign reg_hit   = bus.wbs_cyc_i && bus.wbs_stb_i && !ack_q &&
                     (bus.wbs_adr_i[31:4] == BASE[31:4]);
  assign fifo_push = (state_q == M_RD) && bus.m_ack_i;
  assign fifo_pop  = !fifo_empty && bus.ss_tready;
  assign bus.sm_tready = busy_q && !wbuf_vld_q && (acc_cnt_q < len_q);
  assign sm_accept = bus.sm_tvalid && bus.sm_tready;
  // FIFO will hold nothing after this edge
  assign fifo_nxt_zero = (fifo_empty && !fifo_push) ||
                         ((fifo_cnt == CW'(1)) && fifo_pop && !fifo_push);

  always_comb begin
    ack_d       = 1'b0;
    rdat_d      = '0;
    irq_en_d    = irq_en_q;
    busy_d      = busy_q;
    done_d      = done_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    state_d     = state_q;
    prefer_rd_d = prefer_rd_q;
    adr_d       = adr_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    wbuf_vld_d  = wbuf_vld_q;
    wbuf_d      = wbuf_q;
    rd_req      = 1'b0;
    wr_req      = 1'b0;

    if (sm_accept) begin
      wbuf_vld_d = 1'b1;
      wbuf_d     = bus.sm_tdata;
      acc_cnt_d  = acc_cnt_q + 16'd1;
    end
    if (fifo_pop) pop_cnt_d = pop_cnt_q + 16'd1;

    case (state_q)
      M_IDLE: begin
        // reads are throttled so every outstanding read has a FIFO slot reserved
        rd_req = busy_q && (rd_cnt_q < len_q) && !fifo_full && (fifo_cnt < DEPTH_C);
        wr_req = wbuf_vld_q;
        if (wr_req && (!rd_req || !prefer_rd_q)) begin
          state_d     = M_WR;
          adr_d       = word_addr(dst_q, wr_cnt_q);
          prefer_rd_d = 1'b1;
        end else if (rd_req) begin
          state_d     = M_RD;
          adr_d       = word_addr(src_q, rd_cnt_q);
          prefer_rd_d = 1'b0;
        end
      end
      M_RD: if (bus.m_ack_i) begin
        rd_cnt_d = rd_cnt_q + 16'd1;
        state_d  = M_IDLE;
      end
      M_WR: if (bus.m_ack_i) begin
        wbuf_vld_d = 1'b0;
        wr_cnt_d   = wr_cnt_q + 16'd1;
        state_d    = M_IDLE;
      end
      default: state_d = M_IDLE;
    endcase

    if (busy_q && (rd_cnt_d == len_q) && (wr_cnt_d == len_q) && fifo_nxt_zero) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    if (reg_hit) begin
      ack_d = 1'b1;
      case (bus.wbs_adr_i[3:0])
        OFS_CTRL: begin
          rdat_d[CTRL_BUSY]   = busy_q;
          rdat_d[CTRL_IRQ_EN] = irq_en_q;
          rdat_d[CTRL_DONE]   = done_q;
        end
        OFS_SRC: rdat_d = src_q;
        OFS_DST: rdat_d = dst_q;
        OFS_LEN: rdat_d = {16'b0, len_q};
        default: rdat_d = '0;
      endcase
      if (bus.wbs_we_i) begin
        case (bus.wbs_adr_i[3:0])
          OFS_CTRL: begin
            irq_en_d = bus.wbs_dat_i[CTRL_IRQ_EN];
            if (bus.wbs_dat_i[CTRL_START] && !busy_q) begin
              if (len_q == 16'd0) begin
                done_d = 1'b1;
              end else begin
                busy_d      = 1'b1;
                done_d      = 1'b0;
                rd_cnt_d    = '0;
                wr_cnt_d    = '0;
                acc_cnt_d   = '0;
                pop_cnt_d   = '0;
                prefer_rd_d = 1'b0;
              end
            end
          end
          OFS_SRC: if (!busy_q) src_d = bus.wbs_dat_i;
          OFS_DST: if (!busy_q) dst_d = bus.wbs_dat_i;
          OFS_LEN: if (!busy_q) len_d = bus.wbs_dat_i[15:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      irq_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      state_q     <= M_IDLE;
      prefer_rd_q <= 1'b0;
      adr_q       <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      pop_cnt_q   <= '0;
      wbuf_vld_q  <= 1'b0;
      wbuf_q      <= '0;
    end else begin
      ack_q       <= ack_d;
      rdat_q      <= rdat_d;
      irq_en_q    <= irq_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      state_q     <= state_d;
      prefer_rd_q <= prefer_rd_d;
      adr_q       <= adr_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      wbuf_vld_q  <= wbuf_vld_d;
      wbuf_q      <= wbuf_d;
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = rdat_q;
  assign bus.m_stb_o   = (state_q != M_IDLE);
  assign bus.m_cyc_o   = (state_q != M_IDLE);
  assign bus.m_we_o    = (state_q == M_WR);
  assign bus.m_adr_o   = adr_q;
  assign bus.m_dat_o   = wbuf_q;
  assign bus.ss_tvalid = !fifo_empty;
  assign bus.ss_tdata  = fifo_empty ? '0 : fifo_head;
  assign bus.ss_tlast  = !fifo_empty && (pop_cnt_q == len_q - 16'd1);
  assign bus.irq_o     = done_q && irq_en_q;

endmodule

// File: tb/tb_stream_dma.sv
// Directed bench for stream_dma: memory responder with programmable ack delay,
// S2MM source queue and MM2S sink log, checked against hand-computed values.
`timescale 1ns/1ps
module tb_stream_dma;
  localparam int          DW   = 32;
  localparam int          FD   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_SRC  = BASE + 32'h4;
  localparam logic [31:0] A_DST  = BASE + 32'h8;
  localparam logic [31:0] A_LEN  = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_dma_if #(.DW(DW)) bus ();

  stream_dma #(.DW(DW), .FIFO_DEPTH(FD), .CFG_BASE(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // memory model: word at 0x100 + 4*(n-1) holds n
  function automatic logic [31:0] mem_word(input logic [31:0] adr);
    return ((adr - 32'h100) >> 2) + 32'd1;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // logs
  logic [31:0] tr_adr[$];
  logic [31:0] tr_we[$];
  logic [31:0] tr_dat[$];
  logic [31:0] ss_dat[$];
  logic [31:0] ss_last[$];
  logic [31:0] sm_q[$];
  int   rd_issue = 0;
  int   stb_cycles = 0;
  logic stb_prev = 1'b0;
  logic sm_acc = 1'b0;
  int   ack_dly = 0;

  // memory responder
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.m_ack_i = 1'b0;
    bus.m_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_stb_o && !bus.m_ack_i) begin
        if (wait_cnt >= ack_dly) begin
          bus.m_ack_i = 1'b1;
          bus.m_dat_i = mem_word(bus.m_adr_o);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        bus.m_ack_i = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // S2MM source
  initial begin
    bus.sm_tvalid = 1'b0;
    bus.sm_tdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (sm_acc && sm_q.size() > 0) void'(sm_q.pop_front());
      sm_acc = 1'b0;
      bus.sm_tvalid = (sm_q.size() > 0);
      bus.sm_tdata  = (sm_q.size() > 0) ? sm_q[0] : '0;
    end
  end

  // monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.m_stb_o) stb_cycles++;
    if (bus.m_stb_o && !stb_prev && !bus.m_we_o) rd_issue++;
    stb_prev = bus.m_stb_o;
    if (bus.m_stb_o && bus.m_ack_i) begin
      tr_adr.push_back(bus.m_adr_o);
      tr_we.push_back({31'b0, bus.m_we_o});
      tr_dat.push_back(bus.m_we_o ? bus.m_dat_o : bus.m_dat_i);
    end
    if (bus.ss_tvalid && bus.ss_tready) begin
      ss_dat.push_back(bus.ss_tdata);
      ss_last.push_back({31'b0, bus.ss_tlast});
    end
    sm_acc = bus.sm_tvalid && bus.sm_tready;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic acked);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    acked = 1'b0;
    rdat  = '0;
    for (int n = 0; n < 8 && !acked; n++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdat  = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic reg_wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    logic a;
    wb_xfer(1'b1, adr, dat, d, a);
    check_val("wr_ack", {31'b0, a}, 32'd1);
  endtask

  task automatic reg_rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    logic a;
    wb_xfer(1'b0, adr, 32'h0, d, a);
    check_val(tag, a ? d : 32'hBAD0_ACC0, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ss_tready = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    ack_dly = 0;
    sm_q.delete();
    cycles(2);
    tr_adr.delete(); tr_we.delete(); tr_dat.delete();
    ss_dat.delete(); ss_last.delete();
    rd_issue = 0;
    stb_cycles = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_ss(input int n, input int budget);
    for (int i = 0; i < budget && ss_dat.size() < n; i++) cycles(1);
    check_val("ss_count", 32'(ss_dat.size()), 32'(n));
  endtask

  initial begin
    logic [31:0] d;
    logic a;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.ss_tready = 1'b0;

    // reset state
    rst_n = 1'b0;
    cycles(1);
    check_val("rst_m_stb", {31'b0, bus.m_stb_o}, 32'd0);
    check_val("rst_m_cyc", {31'b0, bus.m_cyc_o}, 32'd0);
    check_val("rst_wbs_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
    check_val("rst_ss_tvalid", {31'b0, bus.ss_tvalid}, 32'd0);
    check_val("rst_sm_tready", {31'b0, bus.sm_tready}, 32'd0);
    check_val("rst_irq", {31'b0, bus.irq_o}, 32'd0);
    check_val("rst_m_adr", bus.m_adr_o, 32'd0);
    check_val("rst_ss_tdata", bus.ss_tdata, 32'd0);
    do_reset();
    reg_rd_chk("rst_ctrl", A_CTRL, 32'h0);
    reg_rd_chk("rst_src", A_SRC, 32'h0);
    reg_rd_chk("rst_len", A_LEN, 32'h0);
    wb_xfer(1'b0, BASE + 32'h40, 32'h0, d, a);
    check_val("oow_no_ack", {31'b0, a}, 32'd0);

    // MM2S LEN=4 from 0x100, then S2MM completes the transfer
    reg_wr(A_SRC, 32'h100);
    reg_wr(A_DST, 32'h400);
    reg_wr(A_LEN, 32'd4);
    bus.ss_tready = 1'b1;
    reg_wr(A_CTRL, 32'h1);
    wait_ss(4, 100);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t1_word%0d", i), q_at(ss_dat, i), 32'(i + 1));
      check_val($sformatf("t1_last%0d", i), q_at(ss_last, i), (i == 3) ? 32'd1 : 32'd0);
    end
    check_val("t1_reads", 32'(rd_issue), 32'd4);
    reg_rd_chk("t1_busy", A_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) sm_q.push_back(32'h5100 + 32'(i));
    cycles(40);
    reg_rd_chk("t1_done", A_CTRL, 32'h4);
    check_val("t1_irq_off", {31'b0, bus.irq_o}, 32'd0);
    check_val("t1_tr_count", 32'(tr_adr.size()), 32'd8);
    check_val("t1_w3_adr", q_at(tr_adr, 7), 32'h40C);
    check_val("t1_w3_dat", q_at(tr_dat, 7), 32'h5103);

    // prefetch throttling: sink stalled, LEN=16, depth 8
    do_reset();
    reg_wr(A_SRC, 32'h100);
    reg_wr(A_LEN, 32'd16);
    reg_wr(A_CTRL, 32'h1);
    cycles(60);
    check_val("t2_reads8", 32'(rd_issue), 32'd8);
    check_val("t2_idle", {31'b0, bus.m_stb_o}, 32'd0);
    check_val("t2_head", bus.ss_tdata, 32'd1);
    cycles(10);
    check_val("t2_still8", 32'(rd_issue), 32'd8);
    bus.ss_tready = 1'b1;
    cycles(1);
    bus.ss_tready = 1'b0;
    cycles(10);
    check_val("t2_after_pop", 32'(rd_issue), 32'd9);
    check_val("t2_popped", q_at(ss_dat, 0), 32'd1);

    // S2MM with interrupt
    do_reset();
    reg_wr(A_CTRL, 32'h2);
    reg_wr(A_SRC, 32'h100);
    reg_wr(A_DST, 32'h200);
    reg_wr(A_LEN, 32'd3);
    bus.ss_tready = 1'b1;
    sm_q.push_back(32'hAAAA_000A);
    sm_q.push_back(32'hBBBB_000B);
    sm_q.push_back(32'hCCCC_000C);
    reg_wr(A_CTRL, 32'h3);
    for (int i = 0; i < 100 && !bus.irq_o; i++) cycles(1);
    check_val("t3_irq", {31'b0, bus.irq_o}, 32'd1);
    reg_rd_chk("t3_ctrl", A_CTRL, 32'h6);
    begin
      logic [31:0] wa[$];
      logic [31:0] wd[$];
      for (int i = 0; i < tr_adr.size(); i++)
        if (tr_we[i] == 32'd1) begin
          wa.push_back(tr_adr[i]);
          wd.push_back(tr_dat[i]);
        end
      check_val("t3_nwr", 32'(wa.size()), 32'd3);
      check_val("t3_wa0", q_at(wa, 0), 32'h200);
      check_val("t3_wa1", q_at(wa, 1), 32'h204);
      check_val("t3_wa2", q_at(wa, 2), 32'h208);
      check_val("t3_wd0", q_at(wd, 0), 32'hAAAA_000A);
      check_val("t3_wd2", q_at(wd, 2), 32'hCCCC_000C);
    end

    // contention with slow acks: first read is uncontended, then W/R alternate
    do_reset();
    ack_dly = 3;
    reg_wr(A_SRC, 32'h100);
    reg_wr(A_DST, 32'h300);
    reg_wr(A_LEN, 32'd4);
    bus.ss_tready = 1'b1;
    for (int i = 0; i < 4; i++) sm_q.push_back(32'h7700 + 32'(i));
    reg_wr(A_CTRL, 32'h1);
    cycles(120);
    check_val("t4_ntr", 32'(tr_adr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = i / 2;
      check_val($sformatf("t4_we%0d", i), q_at(tr_we, i), (i % 2 == 1) ? 32'd1 : 32'd0);
      check_val($sformatf("t4_adr%0d", i), q_at(tr_adr, i),
                ((i % 2 == 1) ? 32'h300 : 32'h100) + 32'(4 * k));
      check_val($sformatf("t4_dat%0d", i), q_at(tr_dat, i),
                (i % 2 == 1) ? 32'h7700 + 32'(k) : 32'(k + 1));
    end
    check_val("t4_ss_n", 32'(ss_dat.size()), 32'd4);
    reg_rd_chk("t4_done", A_CTRL, 32'h4);

    // LEN=0 start
    do_reset();
    reg_wr(A_CTRL, 32'h1);
    reg_rd_chk("t5_len0_done", A_CTRL, 32'h4);
    check_val("t5_no_stb", 32'(stb_cycles), 32'd0);

    // start while busy
    do_reset();
    reg_wr(A_SRC, 32'h100);
    reg_wr(A_LEN, 32'd16);
    reg_wr(A_CTRL, 32'h1);
    cycles(60);
    reg_wr(A_SRC, 32'h800);
    reg_wr(A_LEN, 32'd5);
    reg_wr(A_CTRL, 32'h1);
    cycles(10);
    reg_rd_chk("t5_src_kept", A_SRC, 32'h100);
    reg_rd_chk("t5_len_kept", A_LEN, 32'd16);
    reg_rd_chk("t5_busy", A_CTRL, 32'h1);
    check_val("t5_reads_kept", 32'(rd_issue), 32'd8);
    bus.ss_tready = 1'b1;
    wait_ss(16, 200);
    check_val("t5_w15", q_at(ss_dat, 15), 32'd16);
    check_val("t5_last15", q_at(ss_last, 15), 32'd1);
    check_val("t5_last14", q_at(ss_last, 14), 32'd0);
    check_val("t5_reads16", 32'(rd_issue), 32'd16);

    // reset with a read strobe outstanding
    do_reset();
    ack_dly = 20;
    reg_wr(A_SRC, 32'h100);
    reg_wr(A_LEN, 32'd4);
    reg_wr(A_CTRL, 32'h1);
    for (int i = 0; i < 10 && !bus.m_stb_o; i++) cycles(1);
    check_val("t6_stb_seen", {31'b0, bus.m_stb_o}, 32'd1);
    rst_n = 1'b0;
    cycles(1);
    check_val("t6_stb_drop", {31'b0, bus.m_stb_o}, 32'd0);
    check_val("t6_cyc_drop", {31'b0, bus.m_cyc_o}, 32'd0);
    check_val("t6_fifo_empty", {31'b0, bus.ss_tvalid}, 32'd0);
    check_val("t6_sm_tready", {31'b0, bus.sm_tready}, 32'd0);
    rst_n = 1'b1;
    ack_dly = 0;
    stb_cycles = 0;
    cycles(5);
    check_val("t6_no_restrobe", 32'(stb_cycles), 32'd0);
    reg_rd_chk("t6_ctrl", A_CTRL, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
